// File: rtl/case_7_mul_share_arb.sv
// Round-robin arbiter that time-shares one external signed multiplier
// among NUM_REQ requesters and returns tagged products on one channel.
module case_7_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 9,
    parameter int B_W     = 6,
    parameter int P_W     = 14,
    parameter int CNT_W   = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [P_W-1:0]         rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       ops_done
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [P_W-1:0]  rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [CNT_W-1:0] ops_done_q;

    logic            can_issue;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;
    logic            rsp_hs;

    // A new product can be latched when the holding register is free
    // or is being drained on this very edge.
    assign can_issue = (state_q == EMPTY) || rsp_ready;
    assign rsp_hs    = (state_q == FULL) && rsp_ready;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_vld && can_issue && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // State register of the response holding FSM.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: refill wins over drain, drain empties, else hold.
    always_comb begin
        state_d = state_q;
        if (gnt_vld) begin
            state_d = FULL;
        end else if (rsp_hs) begin
            state_d = EMPTY;
        end
    end

    // Outputs: grant one-hot and steer the winner onto the multiplier.
    always_comb begin
        rsp_valid = (state_q == FULL);
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            mul_din0 = req_a[gnt_idx*A_W +: A_W];
            mul_din1 = req_b[gnt_idx*B_W +: B_W];
        end
    end

    // Capture the product with its tag and advance the pointer on grant.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
        end else if (gnt_vld) begin
            rsp_data_q <= mul_dout;
            rsp_id_q   <= gnt_idx;
            rr_ptr_q   <= gnt_idx;
        end
    end

    // Count completed response handshakes; wraps naturally.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ops_done_q <= '0;
        end else if (rsp_hs) begin
            ops_done_q <= ops_done_q + 1'b1;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign ops_done = ops_done_q;
    assign busy     = rsp_valid || (|req_valid);

endmodule
